// File: rtl/sal_ref_ctrl_if.sv
// Refresh handshake between the refresh controller, the bank controllers and the command scheduler.
// The master side is the refresh controller.
interface sal_ref_ctrl_if #(
    parameter int BK_CNT = 8
);
    logic [BK_CNT-1:0] bk_idle;
    logic [BK_CNT-1:0] ref_pend;
    logic              ref_req;
    logic              ref_gnt;

    modport master (
        input  bk_idle,
        input  ref_gnt,
        output ref_pend,
        output ref_req
    );

    modport slave (
        output bk_idle,
        output ref_gnt,
        input  ref_pend,
        input  ref_req
    );
endinterface

// File: rtl/sal_ref_ctrl.sv
// DDR2 auto-refresh controller: tREFI tick, owed-refresh bookkeeping, bank drain, REF request and tRFC hold-off.
// Optional macro SAL_REF_POSTPONE_EN postpones refresh while traffic is queued, until URGENT_TH refreshes are owed.
`ifndef DRAM_BK_CNT
`define DRAM_BK_CNT 8
`endif

module sal_ref_ctrl #(
    parameter int BK_CNT    = `DRAM_BK_CNT,
    parameter int REFI_W    = 16,
    parameter int RFC_W     = 8,
    parameter int MAX_OWED  = 8,
    parameter int URGENT_TH = 6,
    localparam int OWED_W   = $clog2(MAX_OWED + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ref_en_i,
    input  logic [REFI_W-1:0] t_refi_m1_i,
    input  logic [RFC_W-1:0]  t_rfc_m1_i,
    input  logic              traffic_i,
    sal_ref_ctrl_if.master    ref_if,
    output logic              rfc_busy_o,
    output logic [OWED_W-1:0] owed_cnt_o,
    output logic              ovf_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_REQ,
        ST_RFC
    } state_t;

    state_t              state_reg, state_next;
    logic [REFI_W-1:0]   refi_cnt_reg;
    logic [RFC_W-1:0]    rfc_cnt_reg, rfc_cnt_next;
    logic [OWED_W-1:0]   owed_reg, owed_next;
    logic                ovf_reg, ovf_next;
    logic                tick;
    logic                gnt_acc;
    logic                start_cond;

    assign tick    = ref_en_i && (refi_cnt_reg == '0);
    assign gnt_acc = (state_reg == ST_REQ) && ref_if.ref_gnt;

    // Start decisions look at the owed count including this cycle's tick, so a drain begins right after the tick.
`ifdef SAL_REF_POSTPONE_EN
    assign start_cond = (owed_next >= OWED_W'(URGENT_TH)) ||
                        ((owed_next != '0) && !traffic_i);
`else
    logic unused_cfg;
    assign unused_cfg = ^{traffic_i, URGENT_TH};
    assign start_cond = (owed_next != '0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refi_cnt_reg <= t_refi_m1_i;
        end else if (ref_en_i) begin
            refi_cnt_reg <= tick ? t_refi_m1_i : refi_cnt_reg - 1'b1;
        end
    end

    always_comb begin
        owed_next = owed_reg;
        ovf_next  = ovf_reg;
        if (tick && !gnt_acc) begin
            if (owed_reg == OWED_W'(MAX_OWED)) begin
                ovf_next = 1'b1;
            end else begin
                owed_next = owed_reg + 1'b1;
            end
        end else if (!tick && gnt_acc && (owed_reg != '0)) begin
            owed_next = owed_reg - 1'b1;
        end
    end

    always_comb begin
        state_next   = state_reg;
        rfc_cnt_next = rfc_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (ref_en_i && start_cond) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (&ref_if.bk_idle) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ref_if.ref_gnt) begin
                    state_next   = ST_RFC;
                    rfc_cnt_next = t_rfc_m1_i;
                end
            end
            ST_RFC: begin
                if (rfc_cnt_reg == '0) begin
                    state_next = (ref_en_i && start_cond) ? ST_DRAIN : ST_IDLE;
                end else begin
                    rfc_cnt_next = rfc_cnt_reg - 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            rfc_cnt_reg <= '0;
            owed_reg    <= '0;
            ovf_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rfc_cnt_reg <= rfc_cnt_next;
            owed_reg    <= owed_next;
            ovf_reg     <= ovf_next;
        end
    end

    assign ref_if.ref_pend = {BK_CNT{state_reg != ST_IDLE}};
    assign ref_if.ref_req  = (state_reg == ST_REQ);
    assign rfc_busy_o      = (state_reg == ST_RFC);
    assign owed_cnt_o      = owed_reg;
    assign ovf_err_o       = ovf_reg;

endmodule

// File: tb/tb_sal_ref_ctrl.sv
// Scoreboard bench for sal_ref_ctrl: expected REF-request cycles and tRFC lengths are queued when stimulus
// is driven and checked by negedge monitors when the controller produces them.
module tb_sal_ref_ctrl;
    localparam int BK = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ref_en = 1'b0;
    logic        traffic = 1'b0;
    logic [15:0] t_refi = 16'd99;
    logic [7:0]  t_rfc = 8'd9;
    logic        rfc_busy;
    logic        ovf;
    logic [3:0]  owed;

    sal_ref_ctrl_if #(.BK_CNT(BK)) ref_if ();

    sal_ref_ctrl #(.BK_CNT(BK), .REFI_W(16), .RFC_W(8), .MAX_OWED(8), .URGENT_TH(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ref_en_i    (ref_en),
        .t_refi_m1_i (t_refi),
        .t_rfc_m1_i  (t_rfc),
        .traffic_i   (traffic),
        .ref_if      (ref_if),
        .rfc_busy_o  (rfc_busy),
        .owed_cnt_o  (owed),
        .ovf_err_o   (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int base_cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int exp_req_q[$];
    int exp_rfc_q[$];
    logic req_prev = 1'b0;
    int busy_len = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rel();
        return cyc - base_cyc + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, rel());
        end
    endtask

    // Monitors: REF request rising edge against queued cycle, tRFC pulse length against queued length.
    always @(negedge clk) begin
        if (ref_if.ref_req && !req_prev) begin
            if (exp_req_q.size() == 0) chk("req_unexpected", 32'(rel()), 0);
            else chk("req_cycle", 32'(rel()), 32'(exp_req_q.pop_front()));
        end
        if (rfc_busy) begin
            busy_len <= busy_len + 1;
        end else if (busy_len != 0) begin
            if (exp_rfc_q.size() == 0) chk("rfc_unexpected", 32'(busy_len), 0);
            else chk("rfc_len", 32'(busy_len), 32'(exp_rfc_q.pop_front()));
            busy_len <= 0;
        end
        req_prev <= ref_if.ref_req;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rel(input int k);
        int n = 0;
        while (rel() < k && n < 5000) begin
            step();
            n++;
        end
    endtask

    task automatic wait_req(input string tag, input int budget);
        int n = 0;
        while (!ref_if.ref_req && n < budget) begin
            step();
            n++;
        end
        if (!ref_if.ref_req) chk(tag, 0, 1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (rfc_busy && n < budget) begin
            step();
            n++;
        end
        if (rfc_busy) chk(tag, 1, 0);
    endtask

    task automatic do_grant(input int rfc_len);
        exp_rfc_q.push_back(rfc_len);
        ref_if.ref_gnt = 1'b1;
        step();
        ref_if.ref_gnt = 1'b0;
    endtask

    logic bad;
    int   n;
    int   owed_exp;

    initial begin
        ref_if.bk_idle = '1;
        ref_if.ref_gnt = 1'b0;
        repeat (3) step();
        chk("rst_pend", 32'(ref_if.ref_pend), 0);
        chk("rst_req", 32'(ref_if.ref_req), 0);
        chk("rst_busy", 32'(rfc_busy), 0);
        chk("rst_owed", 32'(owed), 0);
        chk("rst_ovf", 32'(ovf), 0);

        // 1: first refresh after a full tREFI
        rst_n = 1'b1;
        ref_en = 1'b1;
        base_cyc = cyc;
        exp_req_q.push_back(102);
        wait_req("t1_req_timeout", 150);
        do_grant(10);
        chk("t1_owed_after_gnt", 32'(owed), 0);
        chk("t1_busy", 32'(rfc_busy), 1);
        wait_rel(113);
        chk("t1_idle_pend", 32'(ref_if.ref_pend), 0);
        chk("t1_idle_busy", 32'(rfc_busy), 0);

        // 2: one bank busy holds off the request
        ref_if.bk_idle[3] = 1'b0;
        n = 0;
        while (ref_if.ref_pend == '0 && n < 300) begin
            step();
            n++;
        end
        chk("t2_drain_cycle", 32'(rel()), 201);
        bad = 1'b0;
        repeat (20) begin
            step();
            if (ref_if.ref_req || ref_if.ref_pend != 8'hFF) bad = 1'b1;
        end
        chk("t2_hold_off", 32'(bad), 0);
        ref_if.bk_idle[3] = 1'b1;
        exp_req_q.push_back(rel() + 1);
        wait_req("t2_req_timeout", 10);
        do_grant(10);
        wait_idle("t2_rfc_timeout", 20);

        // 3: withheld grant accumulates a second owed refresh, served back-to-back
        exp_req_q.push_back(302);
        wait_req("t3_req_timeout", 100);
        bad = 1'b0;
        repeat (150) begin
            step();
            if (!ref_if.ref_req) bad = 1'b1;
        end
        chk("t3_req_held", 32'(bad), 0);
        chk("t3_owed2", 32'(owed), 2);
        exp_req_q.push_back(464);
        do_grant(10);
        chk("t3_owed1", 32'(owed), 1);
        wait_req("t3_req2_timeout", 30);
        do_grant(10);
        wait_idle("t3_rfc_timeout", 20);
        chk("t3_owed0", 32'(owed), 0);
        chk("t3_idle_pend", 32'(ref_if.ref_pend), 0);

        // 5: no grant, owed saturates and overflow sticks
        exp_req_q.push_back(502);
        wait_req("t5_req_timeout", 60);
        wait_rel(1250);
        chk("t5_owed_sat", 32'(owed), 8);
        chk("t5_ovf_pre", 32'(ovf), 0);
        wait_rel(1301);
        chk("t5_ovf", 32'(ovf), 1);
        chk("t5_owed_hold", 32'(owed), 8);
        chk("t5_req_held", 32'(ref_if.ref_req), 1);
        wait_rel(1310);
        do_grant(5);
        chk("t5_ovf_sticky", 32'(ovf), 1);
        chk("t5_owed7", 32'(owed), 7);

        // 6: reset in the middle of tRFC
        wait_rel(1315);
        rst_n = 1'b0;
        step();
        chk("t6_pend", 32'(ref_if.ref_pend), 0);
        chk("t6_req", 32'(ref_if.ref_req), 0);
        chk("t6_busy", 32'(rfc_busy), 0);
        chk("t6_owed", 32'(owed), 0);
        chk("t6_ovf", 32'(ovf), 0);

        // 4: constant traffic; counter reload after reset sets the tick timing
        rst_n = 1'b1;
        traffic = 1'b1;
        base_cyc = cyc;
`ifdef SAL_REF_POSTPONE_EN
        exp_req_q.push_back(602);
        owed_exp = 5;
        wait_rel(550);
        chk("t4_postponed_owed", 32'(owed), 5);
        chk("t4_postponed_pend", 32'(ref_if.ref_pend), 0);
`else
        exp_req_q.push_back(102);
        owed_exp = 0;
`endif
        wait_req("t4_req_timeout", 700);
        do_grant(10);
        wait_idle("t4_rfc_timeout", 20);
        step();
        step();
        chk("t4_idle_pend", 32'(ref_if.ref_pend), 0);
        chk("t4_owed", 32'(owed), 32'(owed_exp));

        // refresh disabled: counter frozen, nothing new starts
        ref_en = 1'b0;
        traffic = 1'b0;
        repeat (250) step();
        chk("dis_owed", 32'(owed), 32'(owed_exp));
        chk("dis_pend", 32'(ref_if.ref_pend), 0);

        chk("sb_req_empty", 32'(exp_req_q.size()), 0);
        chk("sb_rfc_empty", 32'(exp_rfc_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
